// File: rtl/jt12_ch_pkg.sv
// -----------------------------------------------------------------------------
// jt12_ch_pkg
//   Shared constants and helpers for the per-channel register writer.
//   - Register base addresses of the channel register groups. The low two
//     bits of a register address select the channel inside a part.
//   - Channel-select width and the up_ch packing helper.
//   - Width of the busy counter.
// -----------------------------------------------------------------------------
package jt12_ch_pkg;

    // Register group bases (channel 0 of a part)
    localparam logic [7:0] REG_FNUMLO = 8'hA0;
    localparam logic [7:0] REG_FNUMHI = 8'hA4;
    localparam logic [7:0] REG_ALG    = 8'hB0;
    localparam logic [7:0] REG_PMS    = 8'hB4;

    // Channel select inside a part: sel_reg[1:0], value 3 is unused
    localparam int CH_SEL_W = 2;
    localparam int UP_CH_W  = CH_SEL_W + 1;

    // Busy counter width (BUSY_CYCLES is 1..255)
    localparam int BUSY_W = 8;

    // True when sel addresses the register group starting at base,
    // whatever the channel field is.
    function automatic logic reg_hit(input logic [7:0] sel, input logic [7:0] base);
        return sel[7:CH_SEL_W] == base[7:CH_SEL_W];
    endfunction

    // Channel index as seen by the register file: {part, channel in part}
    function automatic logic [UP_CH_W-1:0] ch_index(input logic part,
                                                   input logic [CH_SEL_W-1:0] chn);
        return {part, chn};
    endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// -----------------------------------------------------------------------------
// jt12_busy_cnt
//   Busy-flag timer. A load pulse starts (or restarts) a down-count of
//   BUSY_CYCLES chip-clock ticks; busy is high while the count is non-zero.
//   Ports:
//     clk    in  1  system clock
//     rst_n  in  1  synchronous reset, active low (clears the count)
//     cen    in  1  chip clock enable; one decrement per enabled clk
//     load   in  1  reload the counter with BUSY_CYCLES
//     busy   out 1  count != 0
//   Parameters:
//     BUSY_CYCLES  ticks busy stays set after a load (1..255)
// -----------------------------------------------------------------------------
module jt12_busy_cnt
    import jt12_ch_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
)(
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic load,
    output logic busy
);

    localparam logic [BUSY_W-1:0] LOAD_VAL = BUSY_W'(BUSY_CYCLES);

    logic [BUSY_W-1:0] cnt;

    // A load has priority over a coincident tick, so the full BUSY_CYCLES
    // ticks always follow the load clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cen && (cnt != '0)) begin
            cnt <= cnt - BUSY_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/jt12_ch_wr.sv
// -----------------------------------------------------------------------------
// jt12_ch_wr
//   CPU-side writer for the per-channel register file (fnum/block, fb/alg,
//   rl/ams/pms). Decodes the two-step bus write (address port, then data
//   port) into the channel index, data byte, the staged fnum-high latch and
//   one-clk update strobes. Also models the chip busy flag on status reads.
//
//   Parameters:
//     NUM_CH       6 = two parts (ch 1-6), 3 = part 0 only, no B4-B6 group
//     BUSY_CYCLES  cen ticks busy stays set after a data write (1..255)
//   Configuration macro:
//     JT12_BUSY_EN  when defined, busy is driven by jt12_busy_cnt;
//                   otherwise busy and dout[7] are constant 0.
//   Ports:
//     clk         in   1  system clock
//     rst_n       in   1  synchronous reset, active low
//     cen         in   1  chip clock enable (only times the busy flag)
//     cs_n        in   1  chip select, active low
//     wr_n        in   1  write strobe, active low
//     addr        in   2  [0]: 0 address port / 1 data port, [1]: part
//     din         in   8  bus write data
//     dout        out  8  status {busy, 7'd0}
//     busy        out  1  busy flag
//     up_ch       out  3  target channel {part, sel[1:0]}
//     latch_fnum  out  6  {block, fnum[10:8]} staged by an A4-A6 write
//     ch_din      out  8  data byte for the up_* strobes
//     up_fnumlo   out  1  A0-A2 written (one clk)
//     up_alg      out  1  B0-B2 written (one clk)
//     up_pms      out  1  B4-B6 written (one clk)
// -----------------------------------------------------------------------------
module jt12_ch_wr
    import jt12_ch_pkg::*;
#(
    parameter int NUM_CH      = 6,
    parameter int BUSY_CYCLES = 32
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic [2:0] up_ch,
    output logic [5:0] latch_fnum,
    output logic [7:0] ch_din,
    output logic       up_fnumlo,
    output logic       up_alg,
    output logic       up_pms
);

    // Second part (ch 4-6) and the stereo/LFO group only exist on 6-channel chips
    localparam logic PART1_EN = (NUM_CH != 3);

    logic                wr_act_p0;
    logic                wr_act_p1;
    logic                wr_evt_p0;
    logic                addr_wr_p0;
    logic                data_wr_p0;
    logic [7:0]          sel_reg;
    logic                part;
    logic [CH_SEL_W-1:0] chn;
    logic                ch_ok;
    logic                hit_fnumlo;
    logic                hit_fnumhi;
    logic                hit_alg;
    logic                hit_pms;

    // ---- stage p0: bus write edge detect and decode ----
    assign wr_act_p0  = ~cs_n & ~wr_n;
    // One event per write access no matter how long wr_n stays low
    assign wr_evt_p0  = wr_act_p0 & ~wr_act_p1;
    assign addr_wr_p0 = wr_evt_p0 & ~addr[0];
    assign data_wr_p0 = wr_evt_p0 &  addr[0];

    assign chn        = sel_reg[CH_SEL_W-1:0];
    // Channel field 3 is a hole in every group on the real chip
    assign ch_ok      = (chn != 2'd3);
    assign hit_fnumlo = reg_hit(sel_reg, REG_FNUMLO);
    assign hit_fnumhi = reg_hit(sel_reg, REG_FNUMHI);
    assign hit_alg    = reg_hit(sel_reg, REG_ALG);
    assign hit_pms    = reg_hit(sel_reg, REG_PMS) & PART1_EN;

    // ---- stage p1: address latch and registered strobes ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_act_p1  <= 1'b0;
            sel_reg    <= 8'h00;
            part       <= 1'b0;
            up_ch      <= '0;
            latch_fnum <= '0;
            ch_din     <= '0;
            up_fnumlo  <= 1'b0;
            up_alg     <= 1'b0;
            up_pms     <= 1'b0;
        end else begin
            wr_act_p1 <= wr_act_p0;
            up_fnumlo <= 1'b0;
            up_alg    <= 1'b0;
            up_pms    <= 1'b0;

            if (addr_wr_p0) begin
                sel_reg <= din;
                part    <= addr[1] & PART1_EN;
            end

            // The data port reuses the part of the last address write
            if (data_wr_p0 && ch_ok) begin
                up_ch     <= ch_index(part, chn);
                ch_din    <= din;
                up_fnumlo <= hit_fnumlo;
                up_alg    <= hit_alg;
                up_pms    <= hit_pms;
                // fnum high byte is staged in one latch shared by all
                // channels; the A0-A2 write later commits it.
                if (hit_fnumhi) begin
                    latch_fnum <= din[5:0];
                end
            end
        end
    end

`ifdef JT12_BUSY_EN
    // Every data write restarts the busy window, even ignored addresses
    jt12_busy_cnt #(
        .BUSY_CYCLES (BUSY_CYCLES)
    ) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .load  (data_wr_p0),
        .busy  (busy)
    );
`else
    logic unused_cen;
    assign unused_cen = cen;
    assign busy       = 1'b0;
`endif

    assign dout = {busy, 7'd0};

endmodule
